// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Memory arbiter state is visible to hazard/stall logic.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores.
// Data side wins in IDLE; the resp cycle hands off to the other side.
module pipeline_mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_resp,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_mbe,
  output logic                    d_resp,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic                    mem_resp,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int MBE_W = DATA_WIDTH / 8;

  arb_state_t state, state_nx;

  logic                  c_read, c_write;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [MBE_W-1:0]      c_mbe;

  logic d_req;
  logic take_i, take_d;

  assign d_req = d_read | d_write;

  always_comb begin
    state_nx = state;
    take_i   = 1'b0;
    take_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req) begin
          state_nx = SERVE_D;
          take_d   = 1'b1;
        end else if (i_read) begin
          state_nx = SERVE_I;
          take_i   = 1'b1;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_nx = d_req ? SERVE_D : IDLE;
          take_d   = d_req;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_nx = i_read ? SERVE_I : IDLE;
          take_i   = i_read;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      c_read  <= 1'b0;
      c_write <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
      c_mbe   <= '0;
    end else begin
      state <= state_nx;
      if (take_d) begin
        c_read  <= d_read;
        c_write <= d_write;
        c_addr  <= d_addr;
        c_wdata <= d_wdata;
        c_mbe   <= d_mbe;
      end else if (take_i) begin
        c_read  <= 1'b1;
        c_write <= 1'b0;
        c_addr  <= i_addr;
        c_wdata <= '0;
        c_mbe   <= '1;
      end
    end
  end

  logic busy;
  assign busy = (state != IDLE);

  // Stale command contents are masked off while idle.
  assign mem_read        = busy & c_read;
  assign mem_write       = busy & c_write;
  assign mem_address     = busy ? c_addr  : '0;
  assign mem_wdata       = busy ? c_wdata : '0;
  assign mem_byte_enable = busy ? c_mbe   : '0;

  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter.
// Inputs change 1ns after rising edges; outputs checked 1ns later.
module tb_pipeline_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_resp;
  logic [31:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mbe;
  logic        d_resp;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_read(i_read),
    .i_addr(i_addr),
    .i_resp(i_resp),
    .i_rdata(i_rdata),
    .d_read(d_read),
    .d_write(d_write),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_mbe(d_mbe),
    .d_resp(d_resp),
    .d_rdata(d_rdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [104:0] obs;
    rst = 1'b0;
    i_read = 0; i_addr = 0;
    d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; d_mbe = 0;
    mem_resp = 0; mem_rdata = 0;
    #1;
    obs = {mem_read, mem_write, mem_address, mem_wdata,
           mem_byte_enable, i_resp, d_resp, 32'h0};
    checks++;
    if (obs !== 105'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    d_read = 1; d_addr = 32'h40;
    tick();
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h40) begin
      errors++;
      $display("FAIL reset_pre_grant rd=%b addr=%h want 1 40",
               mem_read, mem_address);
    end
    #2;
    rst = 1'b0;
    #1;
    obs = {mem_read, mem_write, mem_address, mem_wdata,
           mem_byte_enable, i_resp, d_resp, 32'h0};
    checks++;
    if (obs !== 105'h0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", obs);
    end
    d_read = 0;
    tick();
    rst = 1'b1;
    tick();
    mem_resp = 1; mem_rdata = 32'h1234;
    #1;
    checks++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_stale_resp d=%b i=%b dr=%h want 0 0 0",
               d_resp, i_resp, d_rdata);
    end
    tick();
    mem_resp = 0; mem_rdata = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle rd=%b wr=%b want 0 0",
               mem_read, mem_write);
    end
  endtask

  task automatic test_single_fetch();
    i_read = 1; i_addr = 32'h60;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_latency rd=%b want 0", mem_read);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 ||
        mem_address !== 32'h60 || mem_byte_enable !== 4'hf ||
        mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_cmd rd=%b wr=%b a=%h be=%h wd=%h want 1 0 60 f 0",
               mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata);
    end
    mem_rdata = 32'hffff_ffff;
    tick();
    checks++;
    if (i_resp !== 1'b0 || i_rdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_no_resp i=%b r=%h want 0 0", i_resp, i_rdata);
    end
    tick();
    mem_resp = 1; mem_rdata = 32'h13;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== 32'h13 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp i=%b r=%h d=%b want 1 13 0",
               i_resp, i_rdata, d_resp);
    end
    tick();
    mem_resp = 0; mem_rdata = 0; i_read = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_address !== 32'h0) begin
      errors++;
      $display("FAIL fetch_idle rd=%b a=%h want 0 0", mem_read, mem_address);
    end
  endtask

  task automatic test_conflict();
    i_read = 1; i_addr = 32'h80;
    d_write = 1; d_addr = 32'h100;
    d_wdata = 32'hdeadbeef; d_mbe = 4'b0011;
    tick();
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_address !== 32'h100 || mem_wdata !== 32'hdeadbeef ||
        mem_byte_enable !== 4'b0011) begin
      errors++;
      $display("FAIL conflict_d_cmd rd=%b wr=%b a=%h wd=%h be=%h",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable);
    end
    tick();
    mem_resp = 1; mem_rdata = 32'h55;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== 32'h55) begin
      errors++;
      $display("FAIL conflict_d_resp d=%b i=%b dr=%h want 1 0 55",
               d_resp, i_resp, d_rdata);
    end
    tick();
    mem_resp = 0; mem_rdata = 0; d_write = 0;
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 ||
        mem_address !== 32'h80 || mem_byte_enable !== 4'hf) begin
      errors++;
      $display("FAIL conflict_i_cmd rd=%b wr=%b a=%h be=%h want 1 0 80 f",
               mem_read, mem_write, mem_address, mem_byte_enable);
    end
    mem_resp = 1; mem_rdata = 32'h77;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== 32'h77 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL conflict_i_resp i=%b r=%h d=%b want 1 77 0",
               i_resp, i_rdata, d_resp);
    end
    tick();
    mem_resp = 0; mem_rdata = 0; i_read = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL conflict_idle rd=%b want 0", mem_read);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    d_read = 1; d_addr = 32'h200;
    i_read = 1; i_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_resp = 0;
      exp_addr = (k % 2 == 0) ? 32'h200 : 32'h300;
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_address !== exp_addr) begin
        errors++;
        $display("FAIL b2b_cmd%0d rd=%b a=%h want 1 %h",
                 k, mem_read, mem_address, exp_addr);
      end
      if (k == 3) d_read = 0;
      mem_resp = 1; mem_rdata = 32'h1000 + k;
      #1;
      checks++;
      if ((k % 2 == 0 && (d_resp !== 1'b1 || i_resp !== 1'b0 ||
                          d_rdata !== 32'h1000 + k)) ||
          (k % 2 == 1 && (i_resp !== 1'b1 || d_resp !== 1'b0 ||
                          i_rdata !== 32'h1000 + k))) begin
        errors++;
        $display("FAIL b2b_resp%0d d=%b i=%b dr=%h ir=%h",
                 k, d_resp, i_resp, d_rdata, i_rdata);
      end
    end
    tick();
    mem_resp = 0; mem_rdata = 0; i_read = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle rd=%b want 0", mem_read);
    end
  endtask

  task automatic test_hold();
    d_read = 1; d_addr = 32'h200;
    tick();
    d_addr = 32'h300; d_read = 0;
    #1;
    checks++;
    if (mem_address !== 32'h200 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_change a=%h rd=%b want 200 1",
               mem_address, mem_read);
    end
    tick();
    checks++;
    if (mem_address !== 32'h200 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL hold_next a=%h rd=%b want 200 1", mem_address, mem_read);
    end
    mem_resp = 1; mem_rdata = 32'habcd;
    #1;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== 32'habcd ||
        mem_address !== 32'h200) begin
      errors++;
      $display("FAIL hold_resp d=%b dr=%h a=%h want 1 abcd 200",
               d_resp, d_rdata, mem_address);
    end
    tick();
    mem_resp = 0; mem_rdata = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle rd=%b d=%b want 0 0", mem_read, d_resp);
    end
  endtask

  task automatic test_stray_resp();
    mem_resp = 1; mem_rdata = 32'h9999;
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL stray_resp i=%b d=%b want 0 0", i_resp, d_resp);
    end
    tick();
    mem_resp = 0; mem_rdata = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL stray_state rd=%b wr=%b want 0 0", mem_read, mem_write);
    end
    i_read = 1; i_addr = 32'h44;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h44) begin
      errors++;
      $display("FAIL stray_then_fetch rd=%b a=%h want 1 44",
               mem_read, mem_address);
    end
    mem_resp = 1;
    tick();
    mem_resp = 0; i_read = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_back_to_back();
    test_hold();
    test_stray_resp();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Shares the single physical memory port between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores) of the 5-stage RV32I pipeline.
- Grants one requester at a time and latches that request's command.
- Drives the memory port until mem_resp, then routes the response back to the owning stage.
- Stage-level stalling is derived externally from i_resp/d_resp.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses; byte-enable width is DATA_WIDTH/8.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- i_read  input  1  IF fetch request, held until i_resp
- i_addr  input  ADDR_WIDTH  fetch address
- i_resp  output  1  one-cycle pulse, fetch complete
- i_rdata  output  DATA_WIDTH  fetched word, valid only while i_resp=1
- d_read  input  1  MEM load request, held until d_resp
- d_write  input  1  MEM store request, held until d_resp; never asserted together with d_read
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  DATA_WIDTH  store data
- d_mbe  input  DATA_WIDTH/8  store byte enables
- d_resp  output  1  one-cycle pulse, data access complete
- d_rdata  output  DATA_WIDTH  load data, valid only while d_resp=1
- mem_read  output  1  memory read command
- mem_write  output  1  memory write command
- mem_address  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_byte_enable  output  DATA_WIDTH/8  memory byte enables
- mem_resp  input  1  memory completion, one-cycle pulse
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_resp

Behaviour:
- States: IDLE, SERVE_I, SERVE_D (state register plus latched command register).
- Reset (rst=0, asynchronous):
  - state=IDLE; command register cleared.
  - All outputs 0: mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, i_resp, d_resp.
  - Reset mid-transaction abandons it; no resp is issued; a later mem_resp is ignored.
- IDLE:
  - d_read|d_write -> SERVE_D; otherwise i_read -> SERVE_I.
  - Data side has fixed priority: the older instruction must drain first.
  - On grant, latch the requester's read/write/addr/wdata/mbe into the command register (I side: write=0, mbe=all ones, wdata=0).
- SERVE_x:
  - mem_* outputs come only from the command register, never combinationally from requester inputs.
  - Latency: request seen in IDLE at cycle N -> command on mem_* from cycle N+1.
  - Hold the command until mem_resp=1.
- On mem_resp in SERVE_x:
  - x_resp=1 combinationally in that same cycle; x_rdata=mem_rdata.
  - The other resp output stays 0.
  - Next state is the OTHER side if its request is high (back-to-back, command latched at this edge); otherwise IDLE.
  - The just-served side is never regranted on its resp cycle, even though its request is still asserted.
- i_rdata/d_rdata are 0 whenever their resp is 0.
- mem_resp in IDLE is ignored: no resp is issued and state does not change.
- If a requester drops its request mid-transaction, the transaction still completes and resp still pulses. Input changes after grant do not affect mem_* outputs.
- mem_read and mem_write are never both 1; mem_* commands are all 0 in IDLE.
- Starvation: under continuous traffic the I side is guaranteed service between consecutive D transactions, through the resp-cycle handoff rule.

Decomposition:
- arb_state_t enum (IDLE, SERVE_I, SERVE_D) goes in the shared rv32i_types package, so the hazard/stall logic and the testbench can reference it.
- No sub-module: the command register and FSM stay in one module (about 150 lines).

Test Plan:
- Reset: assert rst=0 while in SERVE_D with mem_read=1 -> all outputs 0 asynchronously; state IDLE after release; a mem_resp pulse then produces no d_resp.
- Single fetch: i_read=1, i_addr=0x60 -> mem_read=1, mem_address=0x60 next cycle; mem_resp with mem_rdata=0x00000013 after 3 cycles -> i_resp=1, i_rdata=0x13 that cycle; state IDLE next cycle.
- Conflict: i_read and d_write raised together (d_addr=0x100, d_wdata=0xDEADBEEF, d_mbe=4'b0011) -> D served first with mem_write=1 and matching fields; on its mem_resp, d_resp=1 and the next cycle shows mem_read=1, mem_address=i_addr.
- Back-to-back fairness: d_read and i_read held continuously -> grants alternate D, I, D, I with no idle cycle between transactions.
- Hold check: change d_addr from 0x200 to 0x300 after grant -> mem_address stays 0x200 until mem_resp.
- Stray response: mem_resp=1 in IDLE -> i_resp=d_resp=0; state unchanged.
